expand: RTL
===========

Name: expand

Overview:
- Inverse of the accumulator-to-image rescale path: converts signed IMG_WIDTH image/bias samples into NUM_WIDTH MAC/ADD-domain numbers.
- Each sample is sign-extended, then left-shifted by the configured shift, then saturated to the signed NUM_WIDTH range.
- Sits between the image/bias buffers and the MAC/ADD array, where it pre-loads accumulators with bias or residual data at accumulator scale.
- Streaming valid/ready on both sides; 2-stage pipeline with full backpressure.

Parameters:
- IMG_WIDTH, 16, signed width of the upstream image sample.
- NUM_WIDTH, 33, signed width of the downstream MAC/ADD number; must be > IMG_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active low.
- cfg_shift  input  8  left-shift amount; any value 0..255 is legal.
- cfg_valid  input  1  cfg_shift is offered.
- cfg_ready  output  1  config can be accepted; high only when both pipeline stages are empty.
- up_data  input  IMG_WIDTH  signed sample.
- up_valid  input  1  up_data is offered.
- up_ready  output  1  block accepts up_data this cycle.
- dn_data  output  NUM_WIDTH  signed expanded number.
- dn_valid  output  1  dn_data is valid.
- dn_ready  input  1  downstream accepts dn_data.
- sat_clear  input  1  synchronous clear of sat_flag and sat_count.
- sat_flag  output  1  sticky; set when any beat has saturated.
- sat_count  output  16  number of saturated beats; holds at 16'hFFFF, does not wrap.

Behaviour:
- Reset (rst_n low, asynchronous): v1 = v2 = 0, dn_valid = 0, dn_data = 0, sat_flag = 0, sat_count = 0, shift_q = 0.
  - Reset taken mid-stream discards all in-flight beats; no partial beat is emitted after release.
- Config:
  - shift_q <= cfg_shift when cfg_valid & cfg_ready.
  - cfg_ready = !v1 & !v2 & !up_valid_accepted_this_cycle, so the shift can never change under in-flight data.
  - When config and data are offered in the same cycle, config wins and up_ready is forced low for that cycle.
- Handshake:
  - ready2 = !v2 | dn_ready.
  - ready1 = !v1 | ready2.
  - up_ready = ready1 & !(cfg_valid & cfg_ready).
  - A beat transfers on each side only when valid & ready are both high.
  - dn_data and dn_valid are stable while dn_valid & !dn_ready.
  - No beat is lost or duplicated under any dn_ready pattern.
- Stage 1 (on up accept):
  - Register the sign-extended sample ext1 (NUM_WIDTH+1 bits) and shift_q; set v1.
  - Clear v1 when stage 1 moves forward with no new beat entering.
- Stage 2 (when v1 & ready2):
  - Compute the exact value ext1 * 2^shift.
  - Overflow when shift > NUM_WIDTH-1, or when any bit at or above position NUM_WIDTH-1 of the product differs from the sign bit.
  - Zero input never overflows, at any shift.
  - Positive overflow gives NUM_MAX = {0, 1...}; negative overflow gives NUM_MIN = {1, 0...}.
  - Otherwise dn_data = the low NUM_WIDTH bits of the product.
  - Register into dn_data and set v2 (dn_valid = v2).
- Latency: 2 cycles from up accept to dn_valid, with dn_ready held high. Throughput is 1 beat/cycle.
- Saturation stats:
  - Counted when a saturated beat is accepted downstream (dn_valid & dn_ready), not when it is computed.
  - sat_clear has priority over a same-cycle increment: the result is count = 0, flag = 0.
- The sign of dn_data always equals the sign of the input sample, including saturated beats.

Decomposition:
- Shared package (extend the existing rescale/MAC constants header):
  - NUM_MAX/NUM_MIN and IMG_MAX/IMG_MIN localparam definitions.
  - A width-generic saturation-detect function used by both expand and the rescale path.
- Sub-module: pipe_stage (one valid/ready register slice with data and valid), instantiated twice.
- Shift/saturate logic stays inline.

Test Plan (IMG_WIDTH = 16, NUM_WIDTH = 33, dn_ready = 1 unless stated):
- Shift and sign-extend: shift = 4, up 16'h0001 -> dn_data 33'h000000010 two cycles after accept. Shift = 8, up 16'hFFFF -> 33'h1FFFFFF00. sat_flag stays 0.
- Saturation boundary:
  - Shift = 17, up 16'h7FFF -> 33'h0FFFE0000, not saturated.
  - Shift = 18, same input -> 33'h0FFFFFFFF; sat_flag = 1, sat_count = 1.
  - Shift = 18, up 16'h8000 -> 33'h100000000; sat_count = 2.
  - Shift = 200, up 16'h0000 -> 0, no saturation.
- Backpressure: stream 8 beats 1..8 at shift = 1 while dn_ready toggles in a random pattern -> output is exactly 2, 4, ..., 16 in order, and dn_data is stable during every stall.
- Config gating:
  - Assert cfg_valid while 2 beats are in flight -> cfg_ready stays 0 until both drain.
  - cfg_valid and up_valid in the same idle cycle -> config accepted, up_ready = 0 that cycle.
- Stats:
  - sat_clear in the same cycle as a saturated beat's accept -> sat_count = 0.
  - Force 65540 saturated beats -> sat_count holds at 16'hFFFF.
- Reset mid-stream: assert rst_n low asynchronously with v1 = v2 = 1 -> dn_valid drops immediately, and no stale beat appears after release.

Source files
------------

// File: rtl/expand_pkg.sv
// Shared constants and helpers for the expand (image -> MAC/ADD domain) and rescale paths.
package expand_pkg;

    localparam int IMG_WIDTH_DEF = 16;
    localparam int NUM_WIDTH_DEF = 33;
    localparam int SAT_VEC_W     = 128;

    localparam logic [NUM_WIDTH_DEF-1:0] NUM_MAX = {1'b0, {(NUM_WIDTH_DEF-1){1'b1}}};
    localparam logic [NUM_WIDTH_DEF-1:0] NUM_MIN = {1'b1, {(NUM_WIDTH_DEF-1){1'b0}}};
    localparam logic [IMG_WIDTH_DEF-1:0] IMG_MAX = {1'b0, {(IMG_WIDTH_DEF-1){1'b1}}};
    localparam logic [IMG_WIDTH_DEF-1:0] IMG_MIN = {1'b1, {(IMG_WIDTH_DEF-1){1'b0}}};

    // Largest / smallest signed value of a given width, zero-extended to SAT_VEC_W.
    function automatic logic [SAT_VEC_W-1:0] max_pattern(input int unsigned width);
        return (SAT_VEC_W'(1) << (width - 1)) - SAT_VEC_W'(1);
    endfunction

    function automatic logic [SAT_VEC_W-1:0] min_pattern(input int unsigned width);
        return SAT_VEC_W'(1) << (width - 1);
    endfunction

    // True when a signed value does not fit in 'width' signed bits:
    // every bit from width-1 upward must match the sign.
    function automatic logic sat_detect(input logic signed [SAT_VEC_W-1:0] value,
                                        input int unsigned width);
        logic signed [SAT_VEC_W-1:0] w_hi;
        w_hi = value >>> (width - 1);
        return !((w_hi == '0) || (&w_hi));
    endfunction

endpackage

// File: rtl/expand_pipe_stage.sv
// One valid/ready register slice; loads whenever its output slot is free or being drained.
module expand_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/expand.sv
// Sign-extends, left-shifts and saturates image/bias samples into the MAC/ADD number domain.
// Two-stage valid/ready pipeline with saturation statistics.
module expand
    import expand_pkg::*;
#(
    parameter int IMG_WIDTH = 16,
    parameter int NUM_WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           cfg_shift,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [IMG_WIDTH-1:0] up_data,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    input  logic                 sat_clear,
    output logic                 sat_flag,
    output logic [15:0]          sat_count
);

    localparam int EXT_W = NUM_WIDTH + 1;
    localparam int S1_W  = EXT_W + 8;
    localparam int S2_W  = NUM_WIDTH + 1;
    localparam logic [NUM_WIDTH-1:0] L_NUM_MAX = NUM_WIDTH'(max_pattern(NUM_WIDTH));
    localparam logic [NUM_WIDTH-1:0] L_NUM_MIN = NUM_WIDTH'(min_pattern(NUM_WIDTH));

    logic [7:0]                  r_shift_q;
    logic [15:0]                 r_sat_count;
    logic                        r_sat_flag;

    logic                        w_cfg_fire;
    logic                        w_up_fire;
    logic                        w_dn_fire;
    logic                        w_ready1;
    logic                        w_ready2;
    logic                        w_v1;
    logic                        w_v2;
    logic [S1_W-1:0]             w_s1_in;
    logic [S1_W-1:0]             w_s1_out;
    logic [EXT_W-1:0]            w_ext1;
    logic [7:0]                  w_shift1;
    logic signed [SAT_VEC_W-1:0] w_prod;
    logic signed [SAT_VEC_W-1:0] w_prod_sh;
    logic                        w_ovf;
    logic [NUM_WIDTH-1:0]        w_num;
    logic [S2_W-1:0]             w_s2_in;
    logic [S2_W-1:0]             w_s2_out;
    logic                        w_sat_bit;

    // Config only lands on an empty pipe, and it wins over a same-cycle data offer.
    assign cfg_ready  = !w_v1 && !w_v2;
    assign w_cfg_fire = cfg_valid && cfg_ready;
    assign up_ready   = w_ready1 && !w_cfg_fire;
    assign w_up_fire  = up_valid && up_ready;
    assign w_dn_fire  = w_v2 && dn_ready;

    assign w_s1_in = {{(EXT_W-IMG_WIDTH){up_data[IMG_WIDTH-1]}}, up_data, r_shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_q <= '0;
        end else if (w_cfg_fire) begin
            r_shift_q <= cfg_shift;
        end
    end

    expand_pipe_stage #(.W(S1_W)) u_stage1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_up_fire),
        .o_ready (w_ready1),
        .i_data  (w_s1_in),
        .o_valid (w_v1),
        .i_ready (w_ready2),
        .o_data  (w_s1_out)
    );

    assign {w_ext1, w_shift1} = w_s1_out;

    // Shifts beyond NUM_WIDTH-1 push a nonzero sample out of range outright,
    // so the wide product only needs to be exact for small shifts.
    always_comb begin
        w_prod    = {{(SAT_VEC_W-EXT_W){w_ext1[EXT_W-1]}}, w_ext1};
        w_prod_sh = w_prod << w_shift1;
        w_ovf     = 1'b0;
        if (w_ext1 != '0) begin
            w_ovf = (int'(w_shift1) > (NUM_WIDTH - 1)) || sat_detect(w_prod_sh, NUM_WIDTH);
        end
        if (w_ovf) begin
            w_num = w_ext1[EXT_W-1] ? L_NUM_MIN : L_NUM_MAX;
        end else begin
            w_num = w_prod_sh[NUM_WIDTH-1:0];
        end
        w_s2_in = {w_ovf, w_num};
    end

    expand_pipe_stage #(.W(S2_W)) u_stage2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w_v1),
        .o_ready (w_ready2),
        .i_data  (w_s2_in),
        .o_valid (w_v2),
        .i_ready (dn_ready),
        .o_data  (w_s2_out)
    );

    assign dn_valid  = w_v2;
    assign dn_data   = w_s2_out[NUM_WIDTH-1:0];
    assign w_sat_bit = w_s2_out[NUM_WIDTH];

    // Saturated beats are counted when they leave, so stalls never double-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
            r_sat_flag  <= 1'b0;
        end else if (sat_clear) begin
            r_sat_count <= '0;
            r_sat_flag  <= 1'b0;
        end else if (w_dn_fire && w_sat_bit) begin
            r_sat_flag <= 1'b1;
            if (r_sat_count != 16'hFFFF) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    assign sat_flag  = r_sat_flag;
    assign sat_count = r_sat_count;

endmodule
